// File: rtl/mem_map_ctrl.sv
// Memory-map controller: page decode for ROM / VGA RAM / main RAM, reset-jump
// phantom, I/O control register (ROM disable, RAM bank) and per-region wait states.
module mem_map_ctrl #(
    parameter int unsigned         ADDR_W     = 16,
    parameter int unsigned         DEC_BITS   = 4,
    parameter logic [DEC_BITS-1:0] ROM_PAGE   = 4'hF,
    parameter logic [DEC_BITS-1:0] VGA_PAGE   = 4'hE,
    parameter int unsigned         ROM_WAIT   = 1,
    parameter int unsigned         VGA_WAIT   = 2,
    parameter int unsigned         RAM_WAIT   = 0,
    parameter int unsigned         BANK_W     = 3,
    parameter logic [7:0]          CTRL_PORT  = 8'h40,
    parameter int unsigned         JUMP_READS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              io_write,
    input  logic [7:0]        io_port,
    input  logic [7:0]        io_data,
    output logic              rom_cs,
    output logic              ram_cs,
    output logic              vgaRam_cs,
    output logic [BANK_W-1:0] bank_adr,
    output logic              wait_n,
    output logic              rom_enabled,
    output logic              jump_active
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t              state;
    logic [2:0]          wait_cnt;
    logic [3:0]          jump_cnt;
    logic                read_q;
    logic [DEC_BITS-1:0] page;
    logic                req;
    logic                rom_sel;
    logic                vga_sel;
    logic                ram_sel;
    logic                start;
    logic [2:0]          w_sel;
    logic                unused_bits;

    assign page        = address[ADDR_W-1 -: DEC_BITS];
    assign unused_bits = &{1'b0, address[ADDR_W-DEC_BITS-1:0], io_data[6:BANK_W]};

    always_comb begin
        req     = memread | memwrite;
        rom_sel = memread & (jump_active | ((page == ROM_PAGE) & rom_enabled));
        vga_sel = req & ~rom_sel & (page == VGA_PAGE) & ~(jump_active & memread);
        ram_sel = req & ~rom_sel & ~vga_sel;
        if (rom_sel)
            w_sel = 3'(ROM_WAIT);
        else if (vga_sel)
            w_sel = 3'(VGA_WAIT);
        else
            w_sel = 3'(RAM_WAIT);
        start     = req & (state == ST_IDLE);
        rom_cs    = rom_sel & ~reset;
        ram_cs    = ram_sel & ~reset;
        vgaRam_cs = vga_sel & ~reset;
        // The start cycle is the first low cycle, so WAIT only holds the line
        // low while cycles remain; a zero count is a single released cycle.
        wait_n    = reset | ~((start & (w_sel != 3'd0)) |
                              ((state == ST_WAIT) & req & (wait_cnt != 3'd0)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_enabled <= 1'b1;
            bank_adr    <= '0;
            jump_active <= (JUMP_READS != 0);
            jump_cnt    <= 4'(JUMP_READS);
            read_q      <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_IDLE;
        end else begin
            read_q <= memread;
            if (io_write && io_port == CTRL_PORT) begin
                rom_enabled <= ~io_data[7];
                bank_adr    <= io_data[BANK_W-1:0];
            end
            if (jump_active && read_q && !memread) begin
                if (jump_cnt <= 4'd1) begin
                    jump_cnt    <= '0;
                    jump_active <= 1'b0;
                end else begin
                    jump_cnt <= jump_cnt - 4'd1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_sel != 3'd0) begin
                            wait_cnt <= w_sel - 3'd1;
                            state    <= ST_WAIT;
                        end else begin
                            state <= ST_READY;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt == 3'd0) begin
                        state <= ST_READY;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_READY: begin
                    if (!req)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Bench for mem_map_ctrl: directed scenarios plus random traffic, compared every
// cycle against a behavioural model of the memory map.
module tb_mem_map_ctrl;

    localparam int ROM_W  = 1;
    localparam int VGA_W  = 2;
    localparam int RAM_W  = 0;
    localparam int JREADS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        memread, memwrite, io_write;
    logic [7:0]  io_port, io_data;
    logic        rom_cs, ram_cs, vgaRam_cs, wait_n, rom_enabled, jump_active;
    logic [2:0]  bank_adr;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    bit       m_rom_en = 1'b1;
    bit [2:0] m_bank   = 3'd0;
    int       m_jump   = JREADS;
    bit       m_prev_rd = 1'b0;
    bit       m_busy   = 1'b0;
    int       m_low    = 0;

    // outputs sampled in the most recent step
    logic s_rom, s_ram, s_vga, s_wait, s_rom_en, s_jump;
    logic [2:0] s_bank;

    mem_map_ctrl #(
        .ADDR_W(16), .DEC_BITS(4), .ROM_PAGE(4'hF), .VGA_PAGE(4'hE),
        .ROM_WAIT(ROM_W), .VGA_WAIT(VGA_W), .RAM_WAIT(RAM_W), .BANK_W(3),
        .CTRL_PORT(8'h40), .JUMP_READS(JREADS)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .memread(memread),
        .memwrite(memwrite), .io_write(io_write), .io_port(io_port), .io_data(io_data),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .vgaRam_cs(vgaRam_cs), .bank_adr(bank_adr),
        .wait_n(wait_n), .rom_enabled(rom_enabled), .jump_active(jump_active)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input int op, input logic [15:0] addr,
                        input logic iow, input logic [7:0] port, input logic [7:0] data);
        bit rd, wr, rq, e_rom, e_vga, e_ram, e_wait;
        bit [3:0] pg;
        int w;
        reset = rst; memread = (op == 1); memwrite = (op == 2); address = addr;
        io_write = iow; io_port = port; io_data = data;
        @(negedge clock);
        rd = (op == 1); wr = (op == 2); rq = rd | wr; pg = addr[15:12];
        e_rom = 0; e_vga = 0; e_ram = 0;
        if (!rst) begin
            if (rd && (m_jump > 0 || (pg == 4'hF && m_rom_en))) e_rom = 1;
            else if (rq && pg == 4'hE) e_vga = 1;
            else if (rq) e_ram = 1;
        end
        w = e_rom ? ROM_W : (e_vga ? VGA_W : RAM_W);
        if (rst || !rq) e_wait = 1;
        else if (!m_busy) e_wait = (w == 0);
        else e_wait = (m_low == 0);

        s_rom = rom_cs; s_ram = ram_cs; s_vga = vgaRam_cs; s_wait = wait_n;
        s_rom_en = rom_enabled; s_bank = bank_adr; s_jump = jump_active;
        cmp("rom_cs", 8'(rom_cs), 8'(e_rom));
        cmp("ram_cs", 8'(ram_cs), 8'(e_ram));
        cmp("vgaRam_cs", 8'(vgaRam_cs), 8'(e_vga));
        cmp("wait_n", 8'(wait_n), 8'(e_wait));
        cmp("rom_enabled", 8'(rom_enabled), 8'(m_rom_en));
        cmp("bank_adr", 8'(bank_adr), 8'(m_bank));
        cmp("jump_active", 8'(jump_active), 8'(m_jump > 0));
        cmp("onehot", 8'($countones({rom_cs, ram_cs, vgaRam_cs}) <= 1), 8'd1);

        if (rst) begin
            m_rom_en = 1; m_bank = 0; m_jump = JREADS; m_prev_rd = 0; m_busy = 0; m_low = 0;
        end else begin
            if (iow && port == 8'h40) begin
                m_rom_en = !data[7];
                m_bank   = data[2:0];
            end
            if (m_prev_rd && !rd && m_jump > 0) m_jump--;
            m_prev_rd = rd;
            if (rq) begin
                if (!m_busy) begin
                    m_busy = 1;
                    m_low  = (w > 0) ? w - 1 : 0;
                end else if (m_low > 0) begin
                    m_low--;
                end
            end else begin
                m_busy = 0;
                m_low  = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int op, keep;
        logic [15:0] a;
        logic [3:0] pg;
        logic iw;
        logic [7:0] pt;

        step(1, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(1, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_rst_rom_en", 8'(s_rom_en), 8'd1);
        cmp("lit_rst_bank", 8'(s_bank), 8'd0);
        cmp("lit_rst_jump", 8'(s_jump), 8'd1);
        cmp("lit_rst_wait", 8'(s_wait), 8'd1);

        // jump phantom: three reads forced to ROM
        step(0, 1, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_jr1_rom", 8'(s_rom), 8'd1);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(0, 1, 16'h1234, 0, 8'h00, 8'h00);
        cmp("lit_jr2_rom", 8'(s_rom), 8'd1);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(0, 1, 16'h8000, 0, 8'h00, 8'h00);
        cmp("lit_jr3_rom", 8'(s_rom), 8'd1);
        cmp("lit_jr3_jump", 8'(s_jump), 8'd1);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(0, 1, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_post_jump", 8'(s_jump), 8'd0);
        cmp("lit_post_ram", 8'(s_ram), 8'd1);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);

        // ROM read: one wait cycle
        step(0, 1, 16'hF100, 0, 8'h00, 8'h00);
        cmp("lit_romrd_cs", 8'(s_rom), 8'd1);
        cmp("lit_romrd_w0", 8'(s_wait), 8'd0);
        step(0, 1, 16'hF100, 0, 8'h00, 8'h00);
        cmp("lit_romrd_w1", 8'(s_wait), 8'd1);
        step(0, 1, 16'hF100, 0, 8'h00, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);

        // shadow write to ROM page lands in RAM
        step(0, 2, 16'hF100, 0, 8'h00, 8'h00);
        cmp("lit_shw_ram", 8'(s_ram), 8'd1);
        cmp("lit_shw_rom", 8'(s_rom), 8'd0);
        cmp("lit_shw_wait", 8'(s_wait), 8'd1);
        step(0, 2, 16'hF100, 0, 8'h00, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);

        // VGA read: two wait cycles, then an aborted one
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        cmp("lit_vga_cs", 8'(s_vga), 8'd1);
        cmp("lit_vga_w0", 8'(s_wait), 8'd0);
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        cmp("lit_vga_w1", 8'(s_wait), 8'd0);
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        cmp("lit_vga_w2", 8'(s_wait), 8'd1);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_vga_abort", 8'(s_wait), 8'd1);
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        cmp("lit_vga_restart", 8'(s_wait), 8'd0);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);

        // control register
        step(0, 0, 16'h0000, 1, 8'h40, 8'h85);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_ctl_rom_en", 8'(s_rom_en), 8'd0);
        cmp("lit_ctl_bank", 8'(s_bank), 8'd5);
        step(0, 1, 16'hF000, 0, 8'h00, 8'h00);
        cmp("lit_romoff_ram", 8'(s_ram), 8'd1);
        step(0, 0, 16'h0000, 1, 8'h40, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_ctl2_rom_en", 8'(s_rom_en), 8'd1);
        cmp("lit_ctl2_bank", 8'(s_bank), 8'd0);
        step(0, 0, 16'h0000, 1, 8'h41, 8'h85);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_port41_rom_en", 8'(s_rom_en), 8'd1);
        cmp("lit_port41_bank", 8'(s_bank), 8'd0);

        // reset in the middle of a VGA wait after a control write
        step(0, 0, 16'h0000, 1, 8'h40, 8'h83);
        step(0, 1, 16'hE000, 0, 8'h00, 8'h00);
        step(1, 1, 16'hE000, 0, 8'h00, 8'h00);
        step(0, 0, 16'h0000, 0, 8'h00, 8'h00);
        cmp("lit_mrst_wait", 8'(s_wait), 8'd1);
        cmp("lit_mrst_rom_en", 8'(s_rom_en), 8'd1);
        cmp("lit_mrst_bank", 8'(s_bank), 8'd0);
        cmp("lit_mrst_jump", 8'(s_jump), 8'd1);

        // random traffic
        op = 0; a = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            keep = ($urandom_range(0, 1) == 1);
            if (!keep) begin
                op = $urandom_range(0, 2);
                case ($urandom_range(0, 3))
                    0: pg = 4'hF;
                    1: pg = 4'hE;
                    default: pg = 4'($urandom_range(0, 15));
                endcase
                a = {pg, 12'($urandom())};
            end
            iw = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0, 1: pt = 8'h40;
                2: pt = 8'h41;
                default: pt = 8'($urandom());
            endcase
            step(($urandom_range(0, 59) == 0), op, a, iw, pt, 8'($urandom()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
